// File: rtl/zap_fetch_queue.sv
// zap_fetch_queue: bundle FIFO between fetch and decode.
// Holds up to DEPTH fetch bundles plus one registered output slot facing decode.
// When the queue is empty and decode is ready, a bundle skips the queue and goes
// straight into the output slot, so an unstalled stream sees one cycle of latency.
module zap_fetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_clear_from_writeback,
   input  logic                     i_clear_from_alu,
   input  logic                     i_clear_from_decode,
   input  logic                     i_code_stall,
   input  logic                     i_stall_from_decode,
   input  logic [31:0]              i_instruction,
   input  logic                     i_valid,
   input  logic                     i_instr_abort,
   input  logic [31:0]              i_pc_plus_8_ff,
   input  logic [31:0]              i_pc_ff,
   input  logic [1:0]               i_taken,
   input  logic [32:0]              i_pred,
   output logic [31:0]              o_instruction,
   output logic                     o_valid,
   output logic                     o_instr_abort,
   output logic [31:0]              o_pc_plus_8_ff,
   output logic [31:0]              o_pc_ff,
   output logic [1:0]               o_taken,
   output logic [32:0]              o_pred,
   output logic                     o_stall,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // One fetch bundle, stored exactly as it arrived (132 bits).
   typedef struct packed {
      logic [31:0] instruction;
      logic        abort;
      logic [31:0] pc_plus_8;
      logic [31:0] pc;
      logic [1:0]  taken;
      logic [32:0] pred;
   } bundle_t;

   bundle_t          mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q,  count_d;
   logic             full_q,   full_d;
   bundle_t          out_q,    out_d;
   logic             out_valid_q, out_valid_d;

   bundle_t          in_bundle;
   logic             clear;
   logic             wr;
   logic             have_entry;
   logic             pop;
   logic             bypass;
   logic             push;

   assign in_bundle = '{instruction: i_instruction,
                        abort:       i_instr_abort,
                        pc_plus_8:   i_pc_plus_8_ff,
                        pc:          i_pc_ff,
                        taken:       i_taken,
                        pred:        i_pred};

   assign clear      = i_clear_from_writeback | i_clear_from_alu | i_clear_from_decode;
   // full is the registered flag, so a pop in the same cycle does not open a slot for a write.
   assign wr         = i_valid & ~i_code_stall & ~full_q;
   assign have_entry = (count_q != '0);
   assign pop        = ~i_stall_from_decode & have_entry;
   assign bypass     = ~i_stall_from_decode & ~have_entry & wr;
   assign push       = wr & ~bypass;

   // Next-state for pointers, occupancy and the output slot during normal operation.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;

      // DEPTH is a power of two, so the pointers wrap for free at DEPTH-1 -> 0.
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);

      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);

      if (!i_stall_from_decode) begin
         if (have_entry) begin
            out_d       = mem_q[rd_ptr_q];
            out_valid_d = 1'b1;
         end else if (wr) begin
            out_d       = in_bundle;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   assign full_d = (count_d == CW'(DEPTH));

   // Control and output-slot registers: reset zeroes everything, a clear empties the queue
   // and invalidates the slot but leaves the slot's payload fields (except abort) untouched.
   always_ff @(posedge i_clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (i_reset) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else if (clear) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         out_q.abort <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Queue storage: written on push only; stale entries are never read because count gates reads.
   always_ff @(posedge i_clk) begin
      // NOTE: the storage array is deliberately not reset; occupancy is tracked by count, so it can map to plain RAM.
      if (!i_reset && !clear && push) begin
         mem_q[wr_ptr_q] <= in_bundle;
      end
   end

   assign o_instruction  = out_q.instruction;
   assign o_instr_abort  = out_q.abort;
   assign o_pc_plus_8_ff = out_q.pc_plus_8;
   assign o_pc_ff        = out_q.pc;
   assign o_taken        = out_q.taken;
   assign o_pred         = out_q.pred;
   assign o_valid        = out_valid_q;
   assign o_stall        = full_q;
   assign o_count        = count_q;

endmodule

// File: doc/zap_fetch_queue.md
# zap_fetch_queue

Instruction queue between the fetch stage and decode. It buffers up to DEPTH fetch bundles (instruction, abort, PC, PC+8, branch-prediction state) so decode back-pressure does not force the I-cache/fetch path to stall on every decode hold cycle. Bundles are presented to decode through a registered output slot. The block flushes on any pipeline clear and raises a registered stall back to fetch when full.

## Interface
- DEPTH, 4, queue entries excluding the output slot; power of two, ≥2.

- i_clk  in  1  clock.
- i_reset  in  1  synchronous reset, active-high.
- i_clear_from_writeback  in  1  flush request, highest clear priority.
- i_clear_from_alu  in  1  flush request.
- i_clear_from_decode  in  1  flush request.
- i_code_stall  in  1  global front-end stall; blocks writes only.
- i_stall_from_decode  in  1  decode cannot accept; output slot holds.
- i_instruction  in  32  instruction from fetch.
- i_valid  in  1  bundle valid from fetch.
- i_instr_abort  in  1  abort/breakpoint tag.
- i_pc_plus_8_ff  in  32  PC+8 (PC+4 in Thumb).
- i_pc_ff  in  32  PC of bundle.
- i_taken  in  2  predicted state.
- i_pred  in  33  BTB hit bit [32] and target [31:0].
- o_instruction, o_instr_abort, o_pc_plus_8_ff, o_pc_ff, o_taken, o_pred  out  32/1/32/32/2/33  bundle to decode.
- o_valid  out  1  output slot holds a valid bundle.
- o_stall  out  1  queue full; fetch must hold its output.
- o_count  out  $clog2(DEPTH)+1  occupied queue entries (output slot not counted).

## Operation
- Payload: 132 bits, {instruction, abort, pc_plus_8, pc, taken, pred}, stored unmodified.
- Storage: circular buffer with rd_ptr/wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH. Count register 0..DEPTH.
- Priority: reset > any clear > normal operation.
- Reset: all outputs 0, o_valid=0, o_stall=0, count=0, pointers 0.
- Clear (any of three): pointers=0, count=0, o_valid=0, o_instr_abort=0. Other output fields hold. The input bundle in the same cycle is dropped. Clear overrides i_stall_from_decode and i_code_stall.
- Write request: wr = i_valid & ~i_code_stall & ~full. full = (count==DEPTH), registered.
- Output slot load, when ~i_stall_from_decode:
  - If count>0: output ← head entry, o_valid=1, pop.
  - Else if wr: output ← input bundle directly (bypass), no enqueue.
  - Else: o_valid=0.
- When i_stall_from_decode=1, the output slot holds all fields. A wr then enqueues.
- wr while the slot is loading from a non-empty queue: enqueue at wr_ptr. The simultaneous push and pop leaves count unchanged.
- Order is strictly FIFO, and bypass occurs only when the queue is empty, so ordering is preserved.
- An abort-tagged bundle is treated as ordinary data. Downstream acts on o_instr_abort.
- o_stall = full. o_count = count.

## Timing
- Latency input→o_valid: 1 cycle when the queue is empty and decode is not stalled. Otherwise 1 + (entries ahead) cycles after decode releases.
- Throughput: 1 bundle/cycle sustained with no decode stall.
- Push into full: blocked. o_stall is high from the cycle after count reaches DEPTH. Fetch holds its bundle, which is written the cycle after o_stall drops, with no duplicate and no loss.
- Full with a pop in the same cycle: the write is still blocked (full is sampled registered). count→DEPTH-1 and o_stall=0 next cycle.
- Empty with decode stalled and no wr: o_valid holds its prior value.
- Pointer wrap: DEPTH-1 → 0 with no bubble.
- Clear takes effect next edge: o_valid=0, o_stall=0, count=0. Reset mid-operation behaves identically, plus the output fields are zeroed.

## Test plan
- Stream: 8 bundles with i_pc_ff=0x100,0x104,…, no stalls -> o_valid next cycle each, o_pc_ff follows 1-cycle delayed, o_count stays 0 (bypass).
- Back-pressure fill (DEPTH=4): hold i_stall_from_decode=1 over 6 valid bundles -> output holds 0x100, o_count reaches 4, o_stall=1, fetch holds 0x114. Release -> outputs 0x104..0x114 in order, no duplicates or gaps.
- Simultaneous push/pop at count=2 -> count stays 2 and order is intact through pointer wrap (wr_ptr 3→0).
- Clear: i_clear_from_alu with count=3 and i_valid=1 -> next cycle o_valid=0, o_count=0, o_stall=0, the input bundle is discarded, and the next bundle 0x200 bypasses.
- i_code_stall=1 with i_valid=1 for 3 cycles -> no enqueue, queue drains to decode normally.
- Abort passthrough: bundle with i_instr_abort=1, i_pred=33'h1_0000_0040, i_taken=2'b10 -> output fields bit-exact, o_instr_abort=1. Reset asserted mid-stream -> all outputs 0 next cycle.
